button_pulse_gen: RTL and testbench
===================================

Name: button_pulse_gen

Overview:
- Debounces a raw mechanical push-button input and emits exactly one single-cycle pulse per accepted press.
- Sits directly upstream of the 4-bit counter; pulse_out drives the counter's enable.
- One press therefore advances the counter by exactly one.
- Includes an input synchronizer, a four-state debounce FSM and a stability counter.

Parameters:
DEBOUNCE_CYCLES, 50000, cycles the synchronized input must stay stable to accept a press or release; legal range 2..2**CNT_WIDTH-1
CNT_WIDTH, 16, width of the stability counter and the repeat counter
ACTIVE_LOW, 0, 1 = button_in is inverted before synchronization (pressed = 0 on the pin)
REPEAT_DELAY, 25000000, cycles held before the first auto-repeat pulse (used only with the optional feature)
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (used only with the optional feature)

Ports:
clock  input  1  system clock; all state is updated on its rising edge
reset  input  1  asynchronous, active-high reset
button_in  input  1  raw asynchronous button level
pulse_out  output  1  one-cycle pulse per accepted press; connects to the counter's enable
level_out  output  1  debounced button level; 1 while the press is accepted

Behaviour:
- Reset (asynchronous, active-high):
  - sync flops, stability counter and repeat counter cleared to 0.
  - FSM forced to IDLE.
  - pulse_out = 0 and level_out = 0 immediately, without waiting for a clock edge.
- Input path:
  - b = button_in XOR ACTIVE_LOW.
  - b passes through two flops (sync1 -> sync2).
  - The FSM sees only sync2.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: sync2 = 1 -> PRESS_WAIT, cnt <= 0.
  - PRESS_WAIT:
    - sync2 = 0 -> IDLE (bounce rejected, no pulse).
    - cnt < DEBOUNCE_CYCLES-1 -> cnt++.
    - cnt = DEBOUNCE_CYCLES-1 -> HELD, pulse_out <= 1 for one cycle.
  - HELD: sync2 = 0 -> RELEASE_WAIT, cnt <= 0.
  - RELEASE_WAIT:
    - sync2 = 1 -> HELD with no new pulse (release bounce is absorbed).
    - cnt < DEBOUNCE_CYCLES-1 -> cnt++.
    - cnt = DEBOUNCE_CYCLES-1 -> IDLE.
- Outputs:
  - pulse_out is registered and high for exactly one cycle per IDLE->PRESS_WAIT->HELD traversal.
  - level_out is registered and equals 1 in HELD and in RELEASE_WAIT.
- Latency:
  - Let E0 be the first rising edge that samples b = 1, with b held stable afterwards.
  - pulse_out and level_out rise after edge E0+DEBOUNCE_CYCLES+2.
  - level_out falls DEBOUNCE_CYCLES+2 edges after the first edge that samples b = 0, given stable release.
- Boundary conditions:
  - A glitch shorter than the acceptance window produces no pulse and leaves level_out unchanged.
  - The stability counter never wraps; it is cleared on every state entry.
  - Reset mid-press aborts the press with no pulse.
  - A button still held when reset deasserts is treated as a new press: pulse after DEBOUNCE_CYCLES+2 edges.
  - pulse_out is never high on two consecutive cycles.

Optional Feature:
- Macro: BUTTON_PULSE_GEN_AUTOREPEAT_EN.
- Defined:
  - On entry to HELD, the repeat counter rc is cleared to 0; it increments every cycle spent in HELD.
  - First extra pulse when rc reaches REPEAT_DELAY-1.
  - After that pulse, rc reloads and a further pulse is emitted every REPEAT_PERIOD cycles while in HELD.
  - rc is frozen during RELEASE_WAIT; a bounce back into HELD resumes from the frozen value.
  - rc is cleared on entry to IDLE.
- Undefined:
  - The repeat counter and its logic are absent.
  - Exactly one pulse per press.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, ACTIVE_LOW=0, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Clean press: button_in 0->1 sampled at E0, held 20 cycles -> pulse_out high only after E6; level_out rises after E6; total pulses = 1.
- Bounce reject: button_in high for 3 cycles, low 2, high 3, then low -> pulse_out never asserts; level_out stays 0.
- Release bounce: accepted press, then button_in low 2 cycles, high 1, low 10 -> no second pulse; level_out falls 6 edges after the final low is sampled.
- Async reset: assert reset mid-PRESS_WAIT (between edges) -> pulse_out and level_out read 0 before the next edge; no pulse. Button held through reset release -> one pulse 6 edges after deassertion.
- ACTIVE_LOW=1 rebuild: button_in 1->0 held -> one pulse after E6; level_out = 1 while the pin is low.
- Macro defined, button held 30 cycles after acceptance -> pulses at acceptance, then 8 cycles later, then every 3 cycles. Macro undefined, same stimulus -> exactly 1 pulse.

Source files
------------

// File: rtl/button_pulse_gen.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM, one pulse per accepted press.
// Define BUTTON_PULSE_GEN_AUTOREPEAT_EN to add auto-repeat pulses while the button stays held.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic pulse_out,
    output logic level_out
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic                 INVERT   = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_WIDTH) - 1) begin : g_bad_debounce
            $error("button_pulse_gen: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
        end
        if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
            $error("button_pulse_gen: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
        end
    endgenerate

    logic                 w_b;
    logic                 w_sync2;
    logic [1:0]           r_sync;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pulse;
    logic                 r_level;

    assign w_b     = button_in ^ INVERT;
    assign w_sync2 = r_sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], w_b};
        end
    end

`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
    // Repeat counter is widened past CNT_WIDTH when the repeat intervals need more bits.
    localparam int RC_SPAN  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RC_WIDTH = ($clog2(RC_SPAN) > CNT_WIDTH) ? $clog2(RC_SPAN) : CNT_WIDTH;
    localparam logic [RC_WIDTH-1:0] RC_DELAY_LAST  = RC_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [RC_WIDTH-1:0] RC_PERIOD_LAST = RC_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [RC_WIDTH-1:0] RC_ONE         = RC_WIDTH'(1);

    logic [RC_WIDTH-1:0] r_rc;
    logic                r_rep_phase;
    logic                w_rep_fire;

    // r_rep_phase is 0 until the first repeat pulse, then selects the shorter period.
    assign w_rep_fire = r_rep_phase ? (r_rc == RC_PERIOD_LAST) : (r_rc == RC_DELAY_LAST);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
            r_rc        <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sync2) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                        r_level <= 1'b1;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                        r_rc        <= '0;
                        r_rep_phase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!w_sync2) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                    else if (w_rep_fire) begin
                        r_pulse     <= 1'b1;
                        r_rc        <= '0;
                        r_rep_phase <= 1'b1;
                    end else begin
                        r_rc <= r_rc + RC_ONE;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // A bounce back returns to HELD silently; the repeat counter stays frozen here.
                    if (w_sync2) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
                        r_rc        <= '0;
                        r_rep_phase <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pulse_out = r_pulse;
    assign level_out = r_level;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Self-checking bench for button_pulse_gen: table vectors, corner-case sequences and random runs
// checked against a behavioural debounce model (active-high and active-low instances side by side).
module tb_button_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic button_raw = 1'b0;
    logic button_n;
    logic pulse_out, level_out;
    logic pulse_al, level_al;

    assign button_n = ~button_raw;

    always #5 clock = ~clock;

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .CNT_WIDTH(8), .ACTIVE_LOW(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .button_in(button_raw),
        .pulse_out(pulse_out), .level_out(level_out)
    );

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(D), .CNT_WIDTH(8), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_al (
        .clock(clock), .reset(reset), .button_in(button_n),
        .pulse_out(pulse_al), .level_out(level_al)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    logic level_seen;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the debounced level flips once the synchronized input has disagreed
    // with it for D+1 consecutive edges; a rising flip is a press pulse.
    logic m_s1, m_s2, m_level, m_pulse;
    int   m_run, m_t;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0; m_t = 0;
    endtask

    task automatic model_step(input logic b);
        logic held_stay;
        held_stay = m_level && (m_run == 0) && m_s2;
        m_pulse = 1'b0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = ~m_level;
                m_run = 0;
                if (m_level) begin
                    m_pulse = 1'b1;
                    m_t = 0;
                end
            end
        end else begin
            m_run = 0;
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
            if (held_stay) begin
                m_t++;
                if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0))
                    m_pulse = 1'b1;
            end
`else
            if (held_stay) m_t++;
`endif
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic tick(input logic b);
        button_raw = b;
        @(posedge clock);
        model_step(b);
        @(negedge clock);
        check("model_pulse", pulse_out, m_pulse);
        check("model_level", level_out, m_level);
        check("al_pulse", pulse_al, m_pulse);
        check("al_level", level_al, m_level);
        if (pulse_out) n_pulses++;
        if (level_out) level_seen = 1'b1;
    endtask

    typedef struct {
        logic b;
        logic exp_pulse;
        logic exp_level;
    } vec_t;

    vec_t vecs[30];

    initial begin
        int exp_clean;
        int exp_hold;
        for (int i = 0; i < 30; i++) begin
            vecs[i].b         = (i < 20);
            vecs[i].exp_pulse = (i == 6);
            vecs[i].exp_level = (i >= 6 && i <= 25);
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
            if (i == 14 || i == 17 || i == 20) vecs[i].exp_pulse = 1'b1;
`endif
        end
`ifdef BUTTON_PULSE_GEN_AUTOREPEAT_EN
        exp_clean = 4;
        exp_hold  = 9;
`else
        exp_clean = 1;
        exp_hold  = 1;
`endif

        // Outputs must be low while reset is asserted, before any clock edge.
        #1;
        check("reset_pulse", pulse_out, 1'b0);
        check("reset_level", level_out, 1'b0);
        check("reset_al_pulse", pulse_al, 1'b0);
        check("reset_al_level", level_al, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (3) tick(1'b0);

        n_pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick(vecs[i].b);
            check("tbl_pulse", pulse_out, vecs[i].exp_pulse);
            check("tbl_level", level_out, vecs[i].exp_level);
            check("tbl_al_level", level_al, vecs[i].exp_level);
        end
        check_int("clean_press_pulses", n_pulses, exp_clean);
        $display("clean press: pulses=%0d", n_pulses);

        n_pulses = 0; level_seen = 1'b0;
        foreach (vecs[i]) begin end
        tick(1); tick(1); tick(1); tick(0); tick(0); tick(1); tick(1); tick(1);
        repeat (10) tick(1'b0);
        check_int("bounce_pulses", n_pulses, 0);
        check("bounce_level", level_seen, 1'b0);
        $display("bounce reject: pulses=%0d", n_pulses);

        // Acceptance window boundary: 4 high samples rejected, 5 accepted.
        for (int len = D; len <= D + 1; len++) begin
            n_pulses = 0;
            repeat (len) tick(1'b1);
            repeat (14) tick(1'b0);
            check_int("window_pulses", n_pulses, (len == D + 1) ? 1 : 0);
            $display("window len=%0d: pulses=%0d", len, n_pulses);
        end

        n_pulses = 0;
        repeat (10) tick(1'b1);
        tick(0); tick(0); tick(1);
        for (int j = 0; j < 10; j++) begin
            tick(1'b0);
            check("release_level", level_out, (j < 6) ? 1'b1 : 1'b0);
        end
        check_int("release_bounce_pulses", n_pulses, 1);
        $display("release bounce: pulses=%0d", n_pulses);

        repeat (4) tick(1'b1);
        #2 reset = 1'b1;
        #1;
        check("areset_pw_pulse", pulse_out, 1'b0);
        check("areset_pw_level", level_out, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        n_pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1);
            check("reset_release_pulse", pulse_out, (k == 6) ? 1'b1 : 1'b0);
        end
        check_int("reset_release_pulses", n_pulses, 1);
        #2 reset = 1'b1;
        #1;
        check("areset_held_level", level_out, 1'b0);
        check("areset_held_al_level", level_al, 1'b0);
        @(negedge clock);
        button_raw = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (4) tick(1'b0);
        $display("async reset: pulses after release=%0d", n_pulses);

        n_pulses = 0;
        repeat (37) tick(1'b1);
        check_int("hold_pulses", n_pulses, exp_hold);
        $display("long hold: pulses=%0d", n_pulses);
        repeat (12) tick(1'b0);

        for (int r = 0; r < 80; r++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = (r % 4 == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(1, 7));
            repeat (len) tick(v);
        end
        $display("random runs done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
